// File: rtl/four_bit_adder.sv
// Registered N-bit ripple-carry adder: {Cout, Sum} <= A + B + Cin on each enabled edge.
// Define FOUR_BIT_ADDER_OVF_EN to add a registered two's-complement overflow output (ovf).
module four_bit_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         valid
`ifdef FOUR_BIT_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  logic [N:0]   c;
  logic [N-1:0] s;

  logic [N-1:0] sum_reg;
  logic         cout_reg;
  logic         valid_reg;

  assign c[0] = Cin;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_fa
      assign s[gi]    = A[gi] ^ B[gi] ^ c[gi];
      assign c[gi+1]  = (A[gi] & B[gi]) | (c[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= en;
      if (en) begin
        sum_reg  <= s;
        cout_reg <= c[N];
      end
    end
  end

  assign Sum   = sum_reg;
  assign Cout  = cout_reg;
  assign valid = valid_reg;

`ifdef FOUR_BIT_ADDER_OVF_EN
  logic ovf_reg;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (en) begin
      ovf_reg <= c[N] ^ c[N-1];
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_four_bit_adder.sv
// Directed self-checking bench for four_bit_adder (N=4 plus an N=8 spot check).
// Overflow checks are active when FOUR_BIT_ADDER_OVF_EN is defined.
module tb_four_bit_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] a, b;
  logic       cin;
  logic [3:0] sum;
  logic       cout, valid;

  logic       en8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8;
  logic       cout8, valid8;

  int compared   = 0;
  int mismatched = 0;

`ifdef FOUR_BIT_ADDER_OVF_EN
  logic ovf, ovf8;
`endif

  always #5 clk = ~clk;

  four_bit_adder #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b), .Cin(cin),
    .Sum(sum), .Cout(cout), .valid(valid)
`ifdef FOUR_BIT_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  four_bit_adder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .A(a8), .B(b8), .Cin(cin8),
    .Sum(sum8), .Cout(cout8), .valid(valid8)
`ifdef FOUR_BIT_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc, input logic ve);
    a = va; b = vb; cin = vc; en = ve;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the N=4 outputs and prints one line for the transaction.
  task automatic chk4(input string tag, input logic [3:0] es, input logic ec, input logic ev);
    $display("%s: A=%b B=%b Cin=%b en=%b -> Sum=%b Cout=%b valid=%b",
             tag, a, b, cin, en, sum, cout, valid);
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
  endtask

  initial begin
    logic [4:0] exp5;
    logic [3:0] av, bv;
    logic       cv;

    en8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

    // 1: reset dominates with all-ones inputs applied
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    #1;
    chk4("reset", 4'b0000, 1'b0, 1'b0);
`ifdef FOUR_BIT_ADDER_OVF_EN
    chk("reset.ovf", 32'(ovf), 32'd0);
`endif
    tick();
    chk4("reset_held", 4'b0000, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 1'b0);
    tick();
    chk4("release_en0", 4'b0000, 1'b0, 1'b0);

    // 2: zero sum, then 5+3 (signed overflow)
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    tick();
    chk4("zero", 4'b0000, 1'b0, 1'b1);
    drive(4'b0101, 4'b0011, 1'b0, 1'b1);
    tick();
    chk4("5p3", 4'b1000, 1'b0, 1'b1);
`ifdef FOUR_BIT_ADDER_OVF_EN
    chk("5p3.ovf", 32'(ovf), 32'd1);
`endif

    // 3: carry-in, then wrap-around
    drive(4'b0111, 4'b0001, 1'b1, 1'b1);
    tick();
    chk4("7p1p1", 4'b1001, 1'b0, 1'b1);
    drive(4'b1111, 4'b0001, 1'b0, 1'b1);
    tick();
    chk4("wrap", 4'b0000, 1'b1, 1'b1);

    // 4: negative+negative overflow, then hold with en=0
    drive(4'b1010, 4'b1100, 1'b1, 1'b1);
    tick();
    chk4("neg_ovf", 4'b0111, 1'b1, 1'b1);
`ifdef FOUR_BIT_ADDER_OVF_EN
    chk("neg_ovf.ovf", 32'(ovf), 32'd1);
`endif
    drive(4'b0001, 4'b0010, 1'b0, 1'b0);
    tick();
    chk4("hold", 4'b0111, 1'b1, 1'b0);
    a = 4'bxxxx; b = 4'bxxxx; cin = 1'bx;
    tick();
    chk4("hold_x", 4'b0111, 1'b1, 1'b0);
`ifdef FOUR_BIT_ADDER_OVF_EN
    chk("hold_x.ovf", 32'(ovf), 32'd1);
`endif

    // 5: max case, then async reset pulse between edges
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    tick();
    chk4("max", 4'b1111, 1'b1, 1'b1);
    drive(4'b0011, 4'b0100, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk4("async_rst", 4'b0000, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    drive(4'b1001, 4'b0110, 1'b0, 1'b1);
    tick();
    chk4("post_rst", 4'b1111, 1'b0, 1'b1);

    // 6: exhaustive back-to-back sweep
    for (int i = 0; i < 512; i++) begin
      av = 4'(i >> 5);
      bv = 4'(i >> 1);
      cv = i[0];
      drive(av, bv, cv, 1'b1);
      exp5 = 5'(av) + 5'(bv) + 5'(cv);
      tick();
      chk4($sformatf("sweep%0d", i), exp5[3:0], exp5[4], 1'b1);
`ifdef FOUR_BIT_ADDER_OVF_EN
      chk($sformatf("sweep%0d.ovf", i), 32'(ovf),
          32'((av[3] == bv[3]) && (exp5[3] != av[3])));
`endif
    end
    en = 1'b0;

    // N=8 spot check
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; en8 = 1'b1;
    tick();
    $display("n8: A=%h B=%h Cin=%b -> Sum=%h Cout=%b valid=%b", a8, b8, cin8, sum8, cout8, valid8);
    chk("n8.sum", 32'(sum8), 32'h00);
    chk("n8.cout", 32'(cout8), 32'd1);
    chk("n8.valid", 32'(valid8), 32'd1);
    en8 = 1'b0;
    tick();
    chk("n8.valid_drop", 32'(valid8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
